// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the divide-by-zero quotient constant.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  // Wide enough for any supported WIDTH; consumers slice what they need.
  localparam logic [63:0] DIVZ_LO = '1;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: radix-2 shift-add, or (with
// MULDIV_DIV_EN) one restoring shift-subtract producing a single quotient bit.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
`ifdef MULDIV_DIV_EN
  input  logic               is_div,
`endif
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mul_sum;
`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   trial;
`endif

  // Multiply: {partial, multiplier}; add on the multiplier LSB, then shift right
  // with the carry entering the top.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    addend   = acc[0] ? opnd : '0;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    // Divide: {remainder, dividend/quotient}; shift left and try the divisor.
    trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (is_div) begin
      if (trial[WIDTH]) begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Divider datapath is present only when MULDIV_DIV_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  op_e               op_in;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_next;
  logic [WIDTH-1:0]  opnd_q;
  logic              neg_q;
  logic [WIDTH-1:0]  hi_q, lo_q;
  logic              done_q;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic              sgn, accept, div_bypass, last_iter;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]  res_hi, res_lo;
`ifdef MULDIV_DIV_EN
  logic              div_q, divz_q, rem_neg_q;
`endif

  assign op_in     = op_e'(op);
  assign sgn       = op_is_signed(op_in);
  assign mag_a     = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (sgn && b[WIDTH-1]) ? -b : b;
  assign accept    = (state_q == IDLE) && start;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULDIV_DIV_EN
  assign div_bypass = 1'b0;
`else
  // Without a divider, a divide completes immediately and leaves HI/LO alone.
  assign div_bypass = accept && op_is_div(op_in);
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .opnd     (opnd_q),
`ifdef MULDIV_DIV_EN
    .is_div   (div_q),
`endif
    .acc_next (acc_next)
  );

  // NOTE: sequential blocks use non-blocking (<=) only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !div_bypass) state_d = CALC;
      CALC:    if (last_iter) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q     <= 1'b0;
      divz_q    <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q  <= '0;
            neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            div_q     <= op_is_div(op_in);
            divz_q    <= (b == '0);
            rem_neg_q <= sgn & a[WIDTH-1];
            if (op_is_div(op_in)) begin
              acc_q  <= {{WIDTH{1'b0}}, mag_a};
              opnd_q <= mag_b;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, mag_b};
              opnd_q <= mag_a;
            end
`else
            acc_q  <= {{WIDTH{1'b0}}, mag_b};
            opnd_q <= mag_a;
`endif
          end
        end
        CALC: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Sign fix-up on the finished accumulator, consumed at the edge ending FIX.
  always_comb begin
    prod   = neg_q ? -acc_q : acc_q;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (div_q) begin
      // On divide-by-zero the remainder is |a|, so the dividend-sign fix
      // reproduces a exactly.
      res_hi = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      res_lo = divz_q ? DIVZ_LO[WIDTH-1:0]
             : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == FIX) || div_bypass;
      if (state_q == FIX) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if ((state_q == IDLE) && !start && hilo_we) begin
        if (hilo_sel) hi_q <= hilo_wdata;
        else          lo_q <= hilo_wdata;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops against a native
// arithmetic model, and hand sequences for MT*, dropped writes and reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op_i;
  logic [W-1:0]  a_i, b_i;
  logic          hilo_we, hilo_sel;
  logic [W-1:0]  hilo_wdata;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .hilo_we(hilo_we), .hilo_sel(hilo_sel), .hilo_wdata(hilo_wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] hi, lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_hi, model_lo;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_op(input logic [1:0] o, input logic [31:0] av, bv,
                                   output logic [31:0] h, output logic [31:0] l);
    longint      sa, sbv, q, r;
    logic [63:0] p;
    sa  = longint'($signed(av));
    sbv = longint'($signed(bv));
    case (o)
      2'b00: p = {32'b0, av} * {32'b0, bv};
      2'b01: p = 64'(sa * sbv);
      default: begin
        if (bv == 32'h0) begin
          p = {av, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          p = {av % bv, av / bv};
        end else begin
          q = sa / sbv;
          r = sa % sbv;
          p = {32'(r), 32'(q)};
        end
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  // Starts at a negedge with the unit idle; returns at the negedge of the done
  // cycle so the next call exercises back-to-back acceptance.
  // mode 1: start + hilo_we pulsed mid-op; mode 2: hilo_we with start.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] av, bv,
                        input logic [31:0] ehi, elo, input int mode);
    exp_t        e, got;
    logic [31:0] prev_hi, prev_lo;
    int          lat;
    prev_hi = model_hi;
    prev_lo = model_lo;
    e.name  = name;
    if (o[1] && !DIV_EN) begin
      e.hi = prev_hi; e.lo = prev_lo; e.lat = 1;
    end else begin
      e.hi = ehi; e.lo = elo; e.lat = W + 2;
    end
    sb.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    start = 1'b1; op_i = o; a_i = av; b_i = bv;
    if (mode == 2) begin
      hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'h55;
    end
    @(posedge clk); #1;
    start = 1'b0; hilo_we = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check({name, " busy"}, 64'(busy), 64'(e.lat > 1));
        if (mode == 2) check({name, " hi kept"}, 64'(hi), 64'(prev_hi));
      end
      if (mode == 1 && lat == 5) begin
        hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'hDEAD;
        start = 1'b1; op_i = OP_DIVU; a_i = 32'd9; b_i = 32'd3;
      end
      if (mode == 1 && lat == 6) begin
        hilo_we = 1'b0; start = 1'b0;
        check({name, " lo kept"}, 64'(lo), 64'(prev_lo));
      end
    end while (!done && lat < 100);
    got = sb.pop_front();
    check({got.name, " latency"}, 64'(lat), 64'(got.lat));
    check({got.name, " hi"}, 64'(hi), 64'(got.hi));
    check({got.name, " lo"}, 64'(lo), 64'(got.lo));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[13];
    logic [1:0]  ro;
    logic [31:0] ra, rb, rh, rl;
    int          cnt;

    vecs[0]  = '{name: "multu max",    op: OP_MULTU, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFE, lo: 32'h0000_0001};
    vecs[1]  = '{name: "mult -3*7",    op: OP_MULT,  a: 32'hFFFF_FFFD, b: 32'h7,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB};
    vecs[2]  = '{name: "div -7/2",     op: OP_DIV,   a: 32'hFFFF_FFF9, b: 32'h2,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD};
    vecs[3]  = '{name: "div min/-1",   op: OP_DIV,   a: 32'h8000_0000, b: 32'hFFFF_FFFF, hi: 32'h0,         lo: 32'h8000_0000};
    vecs[4]  = '{name: "divu by 0",    op: OP_DIVU,  a: 32'h1234,      b: 32'h0,         hi: 32'h1234,      lo: 32'hFFFF_FFFF};
    vecs[5]  = '{name: "multu 3*5",    op: OP_MULTU, a: 32'h3,         b: 32'h5,         hi: 32'h0,         lo: 32'hF};
    vecs[6]  = '{name: "mult min*min", op: OP_MULT,  a: 32'h8000_0000, b: 32'h8000_0000, hi: 32'h4000_0000, lo: 32'h0};
    vecs[7]  = '{name: "mult 7*-1",    op: OP_MULT,  a: 32'h7,         b: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF9};
    vecs[8]  = '{name: "divu 100/7",   op: OP_DIVU,  a: 32'h64,        b: 32'h7,         hi: 32'h2,         lo: 32'hE};
    vecs[9]  = '{name: "div 7/-2",     op: OP_DIV,   a: 32'h7,         b: 32'hFFFF_FFFE, hi: 32'h1,         lo: 32'hFFFF_FFFD};
    vecs[10] = '{name: "div -7/0",     op: OP_DIV,   a: 32'hFFFF_FFF9, b: 32'h0,         hi: 32'hFFFF_FFF9, lo: 32'hFFFF_FFFF};
    vecs[11] = '{name: "multu shift",  op: OP_MULTU, a: 32'h1234_5678, b: 32'h10,        hi: 32'h1,         lo: 32'h2345_6780};
    vecs[12] = '{name: "divu max/1",   op: OP_DIVU,  a: 32'hFFFF_FFFF, b: 32'h1,         hi: 32'h0,         lo: 32'hFFFF_FFFF};

    rst = 1'b1; start = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
    model_hi = '0; model_lo = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset hi", 64'(hi), 64'h0);
    check("reset lo", 64'(lo), 64'h0);
    check("reset busy", 64'(busy), 64'h0);
    check("reset done", 64'(done), 64'h0);

    // MTHI then MTLO, each visible the cycle after the write edge.
    hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hCAFE;
    @(posedge clk); #1 hilo_we = 1'b0;
    @(negedge clk);
    check("mthi hi", 64'(hi), 64'h0000_CAFE);
    check("mthi lo", 64'(lo), 64'h0);
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h1357;
    @(posedge clk); #1 hilo_we = 1'b0;
    @(negedge clk);
    check("mtlo lo", 64'(lo), 64'h1357);
    check("mtlo hi", 64'(hi), 64'h0000_CAFE);
    model_hi = 32'hCAFE;
    model_lo = 32'h1357;

    run_op("multu with we", OP_MULTU, 32'd2, 32'd2, 32'h0, 32'h4, 2);
    run_op("multu mid-op we", OP_MULTU, 32'd3, 32'd5, 32'h0, 32'hF, 1);

    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("no extra done", 64'(cnt), 64'h0);
    check("idle after op", 64'(busy), 64'h0);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0);

    for (int i = 0; i < 8; i++) begin
      ro = 2'(i % 4);
      ra = $urandom;
      rb = (i == 2) ? 32'h0 : ((i % 2 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
      model_op(ro, ra, rb, rh, rl);
      run_op($sformatf("random %0d", i), ro, ra, rb, rh, rl, 0);
    end

    run_op("multu pre-reset", OP_MULTU, 32'h10, 32'h10, 32'h0, 32'h100, 0);

    // Abandon a multiply mid-CALC with an asynchronous reset.
    start = 1'b1; op_i = OP_MULTU; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst mid hi", 64'(hi), 64'h0);
    check("rst mid lo", 64'(lo), 64'h0);
    check("rst mid busy", 64'(busy), 64'h0);
    check("rst mid done", 64'(done), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    model_hi = '0;
    model_lo = '0;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("no done after rst", 64'(cnt), 64'h0);
    check("hi after rst", 64'(hi), 64'h0);

    run_op("multu recover", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 0);
    check("scoreboard empty", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers for the 32-bit MIPS datapath.
- Sits directly downstream of the register file and consumes its two read ports (rs → `a`, rt → `b`).
- Executes MULT/MULTU/DIV/DIVU over multiple cycles.
- Holds results in HI/LO for MFHI/MFLO, whose values the writeback mux returns to the register file.
- Also accepts MTHI/MTLO writes.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width. Iteration count equals `WIDTH`.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: launch an operation; sampled only in IDLE.
- `op` in 2: operation select.
  - 00 MULTU
  - 01 MULT
  - 10 DIVU
  - 11 DIV
- `a` in WIDTH: multiplicand / dividend (rs).
- `b` in WIDTH: multiplier / divisor (rt).
- `hilo_we` in 1: MTHI/MTLO write strobe.
- `hilo_sel` in 1: target of `hilo_we`; 0 = LO, 1 = HI.
- `hilo_wdata` in WIDTH: data for MTHI/MTLO.
- `busy` out 1: high while an operation is in flight; the pipeline stalls MF*/MT*/new ops on it.
- `done` out 1: one-cycle pulse when HI/LO take a new result.
- `hi` out WIDTH: HI register (product high half / remainder).
- `lo` out WIDTH: LO register (product low half / quotient).

## Operation
- Reset values: all outputs are 0 (`busy`, `done`, `hi`, `lo`); FSM goes to IDLE; iteration counter is 0.
- **IDLE**
  - On `start`: latch `op`, latch operand magnitudes, latch sign flags (signed ops only). Go to CALC.
  - Otherwise, on `hilo_we`: write `hilo_wdata` into the register selected by `hilo_sel`.
- **CALC**
  - Runs exactly `WIDTH` cycles, one iteration per cycle.
  - Multiply: radix-2 shift-add over a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - After the last iteration, go to FIX.
- **FIX** (one cycle)
  - Product: negated if the operand signs differ (signed op).
  - Quotient: negated if the operand signs differ.
  - Remainder: takes the sign of the dividend.
  - At the edge ending FIX: write HI/LO, assert `done` for the next cycle, return to IDLE.
- Arithmetic: magnitudes are taken as WIDTH-bit unsigned, so |0x8000_0000| = 0x8000_0000 with no overflow.
  - DIV 0x8000_0000 / 0xFFFF_FFFF → LO = 0x8000_0000, HI = 0.
- Divide by zero (DIVU or DIV): LO = 0xFFFF_FFFF, HI = `a` as latched. Latency is the same as a normal divide.
- `start` while busy: ignored.
- `hilo_we` while busy: dropped.
- `start` and `hilo_we` in the same IDLE cycle: `start` wins and the write is dropped.
- `rst` mid-operation: the operation is abandoned, HI/LO return to 0, and no `done` pulse is produced.

## Timing
- `start` sampled at edge N:
  - `busy` = 1 in cycles N+1 … N+WIDTH+1.
  - `done` = 1 and new `hi`/`lo` visible in cycle N+WIDTH+2 (34 cycles for WIDTH=32).
  - `busy` = 0 in that same cycle, so back-to-back `start` is accepted in the `done` cycle.
- MTHI/MTLO: value is visible on `hi`/`lo` in the cycle after the `hilo_we` edge.
- `hi`/`lo` are register outputs with no combinational path from inputs.
- Operands need only be valid in the `start` cycle.

## Configuration
- `MULDIV_DIV_EN` defined:
  - Divider datapath is present.
  - DIV/DIVU behave as specified above.
- `MULDIV_DIV_EN` undefined:
  - Divider logic is removed.
  - `start` with op 10/11 goes straight to IDLE with no CALC/FIX.
  - `busy` stays 0 and `done` pulses in cycle N+1.
  - HI/LO are unchanged.
  - Multiply and MT* are unaffected.

## Structure
- `muldiv_pkg` holds:
  - op encodings (`OP_MULTU`, `OP_MULT`, `OP_DIVU`, `OP_DIV`);
  - the FSM state enum (IDLE, CALC, FIX);
  - the `DIVZ_LO` constant (all ones).
- One sub-module, `muldiv_step`: combinational single-iteration datapath. It takes the accumulator, operand and mode, and returns the next accumulator (shift-add or trial subtract). The top level holds the FSM, counter, sign fix-up and HI/LO registers.

## Test plan
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001; `done` 34 cycles after `start`.
- MULT a=0xFFFF_FFFD (−3), b=7 → HI=0xFFFF_FFFF, LO=0xFFFF_FFEB (−21).
- DIV a=−7, b=2 → LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1).
- DIV a=0x8000_0000, b=0xFFFF_FFFF → LO=0x8000_0000, HI=0.
- DIVU a=0x1234, b=0 → LO=0xFFFF_FFFF, HI=0x1234.
- MTHI 0xCAFE in IDLE → `hi`=0xCAFE next cycle; then `start` MULTU 3×5 with `hilo_we` asserted mid-op → write dropped, LO=15, HI=0.
- `rst` pulsed during CALC → HI/LO/`busy`/`done` all 0 and no later `done` pulse.
